// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states and flag indices.
// Imported by the top level and by the multiplier.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_NOT = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_XOR = 4'd5,
        OP_LTU = 4'd6,
        OP_EQ  = 4'd7,
        OP_LTS = 4'd8,
        OP_SHL = 4'd9,
        OP_SHR = 4'd10,
        OP_SRA = 4'd11,
        OP_MUL = 4'd12
    } op_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MUL_RUN = 1'b1
    } state_e;

    localparam int FLAG_CARRY = 0;
    localparam int FLAG_ZERO  = 1;
    localparam int FLAG_OVF   = 2;
    localparam int FLAG_NEG   = 3;
    localparam int FLAG_ERR   = 4;
    localparam int NFLAGS     = 5;

endpackage

// File: rtl/alu_seq_mul.sv
// Shift-add unsigned multiplier, one partial product per step.
// The product of the last step is presented combinationally with o_done.
import alu_seq_pkg::*;

module alu_seq_mul #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic               i_step,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_prod
);

    localparam int RW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [RW-1:0]    r_acc;
    logic [RW-1:0]    r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [CW-1:0]    r_count;

    logic [RW-1:0]    w_addend;
    logic [RW-1:0]    w_next_acc;

    assign w_addend   = r_mplier[0] ? r_mcand : '0;
    assign w_next_acc = r_acc + w_addend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_count  <= '0;
        end else if (i_start) begin
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, i_a};
            r_mplier <= i_b;
            r_count  <= '0;
        end else if (i_step) begin
            r_acc    <= w_next_acc;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + CW'(1);
        end
    end

    assign o_done = i_step && (r_count == LAST);
    assign o_prod = w_next_acc;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready in and out, registered result and flags.
// Single-cycle ops complete on the accept edge; MUL runs WIDTH more cycles.
import alu_seq_pkg::*;

module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic [4:0]         flags
);

    localparam int RW = 2 * WIDTH;
    localparam int SW = $clog2(WIDTH);

    state_e              r_state;
    state_e              w_state_next;
    logic [RW-1:0]       r_result;
    logic [NFLAGS-1:0]   r_flags;
    logic                r_out_valid;

    logic                w_accept;
    logic                w_is_mul;
    logic                w_mul_start;
    logic                w_mul_step;
    logic                w_mul_done;
    logic [RW-1:0]       w_mul_prod;
    logic [NFLAGS-1:0]   w_mul_flags;

    logic [WIDTH:0]      w_sum;
    logic [WIDTH-1:0]    w_diff;
    logic [SW-1:0]       w_shamt;
    logic [WIDTH-1:0]    w_lo;
    logic                w_c;
    logic                w_v;
    logic                w_err;
    logic [NFLAGS-1:0]   w_sc_flags;

    assign w_is_mul = (op == OP_MUL);

    // Single-cycle datapath
    always_comb begin
        w_sum   = {1'b0, a} + {1'b0, b};
        w_diff  = a + ~b + WIDTH'(1);
        w_shamt = b[SW-1:0];
        w_lo    = '0;
        w_c     = 1'b0;
        w_v     = 1'b0;
        w_err   = 1'b0;
        case (op)
            OP_ADD: begin
                w_lo = w_sum[WIDTH-1:0];
                w_c  = w_sum[WIDTH];
                w_v  = (a[WIDTH-1] == b[WIDTH-1]) &&
                       (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                w_lo = w_diff;
                w_c  = (a < b);
                w_v  = (a[WIDTH-1] != b[WIDTH-1]) &&
                       (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_NOT: w_lo = ~a;
            OP_AND: w_lo = a & b;
            OP_OR:  w_lo = a | b;
            OP_XOR: w_lo = a ^ b;
            OP_LTU: w_lo = WIDTH'(a < b);
            OP_EQ:  w_lo = WIDTH'(a == b);
            OP_LTS: w_lo = WIDTH'($signed(a) < $signed(b));
            OP_SHL: w_lo = a << w_shamt;
            OP_SHR: w_lo = a >> w_shamt;
            OP_SRA: w_lo = $signed(a) >>> w_shamt;
            OP_MUL: w_lo = '0;
            default: w_err = 1'b1;
        endcase
    end

    always_comb begin
        w_sc_flags             = '0;
        w_sc_flags[FLAG_CARRY] = w_c;
        w_sc_flags[FLAG_ZERO]  = (w_lo == '0);
        w_sc_flags[FLAG_OVF]   = w_v;
        w_sc_flags[FLAG_NEG]   = w_lo[WIDTH-1] && !w_err;
        w_sc_flags[FLAG_ERR]   = w_err;
    end

    always_comb begin
        w_mul_flags             = '0;
        w_mul_flags[FLAG_CARRY] = |w_mul_prod[RW-1:WIDTH];
        w_mul_flags[FLAG_ZERO]  = (w_mul_prod == '0);
        w_mul_flags[FLAG_NEG]   = w_mul_prod[RW-1];
    end

    alu_seq_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_mul_start),
        .i_step  (w_mul_step),
        .i_a     (a),
        .i_b     (b),
        .o_done  (w_mul_done),
        .o_prod  (w_mul_prod)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_is_mul) begin
                    w_state_next = ST_MUL_RUN;
                end
            end
            ST_MUL_RUN: begin
                if (w_mul_done) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready    = (r_state == ST_IDLE) && (!r_out_valid || out_ready);
        w_accept    = in_valid && in_ready;
        w_mul_start = w_accept && w_is_mul;
        w_mul_step  = (r_state == ST_MUL_RUN);
    end

    // A new result may load on the same edge the old one is consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result    <= '0;
            r_flags     <= '0;
            r_out_valid <= 1'b0;
        end else if (w_accept && !w_is_mul) begin
            r_result    <= {{WIDTH{1'b0}}, w_lo};
            r_flags     <= w_sc_flags;
            r_out_valid <= 1'b1;
        end else if (w_mul_done) begin
            r_result    <= w_mul_prod;
            r_flags     <= w_mul_flags;
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flags     = r_flags;

endmodule
